// File: rtl/rf_arb_pkg.sv
// Shared defaults and types for the register-file writeback arbiter.
package rf_arb_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int ZERO_REG   = 0;

  typedef logic port_idx_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a loser-priority pointer, advanced on transfer.
module rr_arb2
  import rf_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  port_idx_t rr_ptr;

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (rr_ptr == 1'b0) ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  // Point at the port that did not win, so it is favoured next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= 1'b0;
    else if (advance)
      rr_ptr <= grant[0] ? 1'b1 : 1'b0;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates ALU/memory writebacks onto one registered register-file write port.
// Optional read-side forwarding outputs are enabled with macro RF_ARB_FWD_EN.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              stall,
`ifdef RF_ARB_FWD_EN
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2,
`endif
  output logic              WriteEnable,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] DstData
);

  logic [1:0]        grant;
  logic              transfer;
  port_idx_t         sel;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1_valid, req0_valid}),
    .advance (transfer),
    .grant   (grant)
  );

  assign req0_ready = grant[0] & ~stall & ~rst;
  assign req1_ready = grant[1] & ~stall & ~rst;
  assign transfer   = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  assign sel      = grant[1];
  assign sel_addr = (sel == 1'b1) ? req1_addr : req0_addr;
  assign sel_data = (sel == 1'b1) ? req1_data : req0_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WriteEnable <= 1'b0;
      WriteReg    <= '0;
      DstData     <= '0;
    end else if (!stall) begin
      if (transfer) begin
        WriteEnable <= (sel_addr != ADDR_W'(ZERO_REG));
        WriteReg    <= sel_addr;
        DstData     <= sel_data;
      end else begin
        WriteEnable <= 1'b0;
      end
    end
  end

`ifdef RF_ARB_FWD_EN
  assign fwd_hit1  = WriteEnable & (WriteReg == rd_addr1) & (rd_addr1 != ADDR_W'(ZERO_REG));
  assign fwd_hit2  = WriteEnable & (WriteReg == rd_addr2) & (rd_addr2 != ADDR_W'(ZERO_REG));
  assign fwd_data1 = DstData;
  assign fwd_data2 = DstData;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter (forwarding cases under RF_ARB_FWD_EN).
module tb_rf_write_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_addr, req1_addr;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        stall;
  logic        WriteEnable;
  logic [3:0]  WriteReg;
  logic [15:0] DstData;
`ifdef RF_ARB_FWD_EN
  logic [3:0]  rd_addr1, rd_addr2;
  logic        fwd_hit1, fwd_hit2;
  logic [15:0] fwd_data1, fwd_data2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_addr   (req0_addr),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_addr   (req1_addr),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .stall       (stall),
`ifdef RF_ARB_FWD_EN
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .fwd_hit1    (fwd_hit1),
    .fwd_hit2    (fwd_hit2),
    .fwd_data1   (fwd_data1),
    .fwd_data2   (fwd_data2),
`endif
    .WriteEnable (WriteEnable),
    .WriteReg    (WriteReg),
    .DstData     (DstData)
  );

  task automatic clear_inputs();
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    stall = 1'b0;
`ifdef RF_ARB_FWD_EN
    rd_addr1 = '0; rd_addr2 = '0;
`endif
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 16'h1234;
    req1_valid = 1'b1;
    #2;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b%b want 00", req1_ready, req0_ready);
    end
    tick();
    checks++;
    if (WriteEnable !== 1'b0 || WriteReg !== 4'd0 || DstData !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b reg=%0d data=%h want 0/0/0000",
               WriteEnable, WriteReg, DstData);
    end
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic test_single_req0();
    do_reset();
    req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 16'h1234;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: got %b%b want 01", req1_ready, req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    checks++;
    if (WriteEnable !== 1'b1 || WriteReg !== 4'd3 || DstData !== 16'h1234) begin
      errors++;
      $display("FAIL single_write: got we=%b reg=%0d data=%h want 1/3/1234",
               WriteEnable, WriteReg, DstData);
    end
    tick();
    checks++;
    if (WriteEnable !== 1'b0 || WriteReg !== 4'd3 || DstData !== 16'h1234) begin
      errors++;
      $display("FAIL idle_hold: got we=%b reg=%0d data=%h want 0/3/1234",
               WriteEnable, WriteReg, DstData);
    end
  endtask

  task automatic test_alternate();
    logic [3:0]  exp_addr;
    logic [15:0] exp_data;
    logic        exp_r1;
    do_reset();
    req0_valid = 1'b1; req0_addr = 4'd5; req0_data = 16'hAAAA;
    req1_valid = 1'b1; req1_addr = 4'd6; req1_data = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      exp_r1   = (i % 2 == 1);
      exp_addr = exp_r1 ? 4'd6 : 4'd5;
      exp_data = exp_r1 ? 16'h5555 : 16'hAAAA;
      #1;
      checks++;
      if (req1_ready !== exp_r1 || req0_ready !== ~exp_r1) begin
        errors++;
        $display("FAIL alt_ready[%0d]: got %b%b want %b%b", i, req1_ready, req0_ready,
                 exp_r1, ~exp_r1);
      end
      tick();
      checks++;
      if (WriteEnable !== 1'b1 || WriteReg !== exp_addr || DstData !== exp_data) begin
        errors++;
        $display("FAIL alt_write[%0d]: got we=%b reg=%0d data=%h want 1/%0d/%h", i,
                 WriteEnable, WriteReg, DstData, exp_addr, exp_data);
      end
    end
    clear_inputs();
  endtask

  task automatic test_zero_reg();
    do_reset();
    req1_valid = 1'b1; req1_addr = 4'd0; req1_data = 16'hFFFF;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_ready: got %b want 1", req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    checks++;
    if (WriteEnable !== 1'b0 || WriteReg !== 4'd0 || DstData !== 16'hFFFF) begin
      errors++;
      $display("FAIL zero_write: got we=%b reg=%0d data=%h want 0/0/ffff",
               WriteEnable, WriteReg, DstData);
    end
  endtask

  task automatic test_stall();
    do_reset();
    req0_valid = 1'b1; req0_addr = 4'd7; req0_data = 16'h0777;
    tick();
    req0_addr = 4'd8; req0_data = 16'h0888;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (req0_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready[%0d]: got %b want 0", i, req0_ready);
      end
      tick();
      checks++;
      if (WriteEnable !== 1'b1 || WriteReg !== 4'd7 || DstData !== 16'h0777) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got we=%b reg=%0d data=%h want 1/7/0777", i,
                 WriteEnable, WriteReg, DstData);
      end
    end
    stall = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL unstall_ready: got %b want 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    checks++;
    if (WriteEnable !== 1'b1 || WriteReg !== 4'd8 || DstData !== 16'h0888) begin
      errors++;
      $display("FAIL unstall_write: got we=%b reg=%0d data=%h want 1/8/0888",
               WriteEnable, WriteReg, DstData);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0_valid = 1'b1; req0_addr = 4'd2; req0_data = 16'h2222;
    tick();
    req0_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (WriteEnable !== 1'b0 || WriteReg !== 4'd0 || DstData !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset: got we=%b reg=%0d data=%h want 0/0/0000",
               WriteEnable, WriteReg, DstData);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (WriteEnable !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_we[%0d]: got %b want 0", i, WriteEnable);
      end
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_addr = 4'd4; req1_addr = 4'd5;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_ptr: got %b%b want 01", req1_ready, req0_ready);
    end
    clear_inputs();
    tick();
  endtask

`ifdef RF_ARB_FWD_EN
  task automatic test_forward();
    do_reset();
    req0_valid = 1'b1; req0_addr = 4'd9; req0_data = 16'h9999;
    tick();
    req0_valid = 1'b0;
    rd_addr1 = 4'd9; rd_addr2 = 4'd0;
    #1;
    checks++;
    if (fwd_hit1 !== 1'b1 || fwd_data1 !== 16'h9999 || fwd_hit2 !== 1'b0) begin
      errors++;
      $display("FAIL fwd_hit: got h1=%b d1=%h h2=%b want 1/9999/0", fwd_hit1, fwd_data1,
               fwd_hit2);
    end
    rd_addr2 = 4'd9; rd_addr1 = 4'd8;
    #1;
    checks++;
    if (fwd_hit2 !== 1'b1 || fwd_data2 !== 16'h9999 || fwd_hit1 !== 1'b0) begin
      errors++;
      $display("FAIL fwd_hit2: got h1=%b h2=%b d2=%h want 0/1/9999", fwd_hit1, fwd_hit2,
               fwd_data2);
    end
    clear_inputs();
  endtask
`endif

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_req0();
    test_alternate();
    test_zero_reg();
    test_stall();
    test_reset_mid();
`ifdef RF_ARB_FWD_EN
    test_forward();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
